// File: rtl/tt_um_uabc_spi_regs.sv
// tt_um_uabc_spi_regs: SPI mode-0 responder with four 8-bit registers.
// Define SPI_TXN_COUNT_EN to make REG3 count completed write frames (else REG3 reads 8'hA5).
module tt_um_uabc_spi_regs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] sclk_m, mosi_m, cs_m;
    logic sclk_d, cs_d, sclk_s, mosi_s, cs_s, rise, fall, cs_fall, last, wr, miso;
    logic [3:0] cnt;
    logic [6:0] sh;
    logic [7:0] tx, r0, r1, r2, r3, cmd_byte, rd_val;
    logic [1:0] addr;
    logic unused_bits;
    assign unused_bits = &{1'b0, uio_in, ui_in[7:3], r1[7]};
    assign sclk_s = sclk_m[1];
    assign mosi_s = mosi_m[1];
    assign cs_s = cs_m[1];
    assign rise = sclk_s & ~sclk_d;
    assign fall = ~sclk_s & sclk_d;
    assign cs_fall = ~cs_s & cs_d;
    assign cmd_byte = {sh, mosi_s};
    assign last = state == DATA && rise && cnt == 4'd15;
`ifdef SPI_TXN_COUNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r3 <= 8'h00;
        else if (last && wr) r3 <= r3 + 8'd1;
`else
    assign r3 = 8'hA5;
`endif
    assign rd_val = cmd_byte[1:0] == 2'd0 ? r0 : cmd_byte[1:0] == 2'd1 ? r1 :
                    cmd_byte[1:0] == 2'd2 ? r2 : r3;
    assign miso = state == DATA && !wr ? tx[7] : 1'b0;
    assign uo_out = {r1[6:0], miso};
    assign uio_out = r0;
    assign uio_oe = 8'hFF;
    always_comb begin
        state_nx = state;
        state_nx = cs_s ? IDLE :
                   (state == IDLE && cs_fall) ? CMD :
                   (state == CMD && rise && cnt == 4'd7) ? DATA :
                   last ? DONE : state;
    end
    // CS_N synchronizer resets to asserted so a CS_N held low across reset never looks like a fresh fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m <= 2'b00;
            mosi_m <= 2'b00;
            cs_m <= 2'b00;
            sclk_d <= 1'b0;
            cs_d <= 1'b0;
            state <= IDLE;
            cnt <= 4'd0;
            sh <= 7'd0;
            tx <= 8'h00;
            wr <= 1'b0;
            addr <= 2'd0;
            r0 <= 8'h00;
            r1 <= 8'h00;
            r2 <= 8'h00;
        end else begin
            sclk_m <= {sclk_m[0], ui_in[0]};
            mosi_m <= {mosi_m[0], ui_in[1]};
            cs_m <= {cs_m[0], ui_in[2] | ~ena};
            sclk_d <= sclk_s;
            cs_d <= cs_s;
            state <= state_nx;
            if (state == IDLE) begin
                cnt <= 4'd0;
                sh <= 7'd0;
            end else if (rise && (state == CMD || state == DATA)) begin
                cnt <= cnt + 4'd1;
                sh <= {sh[5:0], mosi_s};
            end
            if (state == CMD && rise && cnt == 4'd7) begin
                wr <= cmd_byte[7];
                addr <= cmd_byte[1:0];
                tx <= rd_val;
            end else if (state == DATA && fall && cnt != 4'd8) begin
                tx <= {tx[6:0], 1'b0};
            end
            if (last && wr && addr == 2'd0) r0 <= cmd_byte;
            if (last && wr && addr == 2'd1) r1 <= cmd_byte;
            if (last && wr && addr == 2'd2) r2 <= cmd_byte;
        end
    end
endmodule

// File: tb/tb_tt_um_uabc_spi_regs.sv
// tb_tt_um_uabc_spi_regs: scoreboard bench; the driver queues expected values, the monitor pops and compares.
module tb_tt_um_uabc_spi_regs;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic [7:0] miso_sh = 8'h00;
    int errors = 0, checks = 0, nwr = 0;
    typedef struct {string name; int kind; logic [7:0] exp;} exp_t;
    exp_t q[$];
    event obs_ev;

    assign ui_in = {5'b0, cs_n, mosi, sclk};
    assign uio_in = 8'h00;

    tt_um_uabc_spi_regs dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;
    always @(posedge sclk) miso_sh <= {miso_sh[6:0], uo_out[0]};

    initial begin : monitor
        exp_t e;
        logic [7:0] act;
        forever begin
            @(obs_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = e.kind == 0 ? uio_out : e.kind == 1 ? {1'b0, uo_out[7:1]} :
                      e.kind == 2 ? miso_sh : e.kind == 3 ? uio_oe : uo_out;
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic expect_now(input string n, input int k, input logic [7:0] v);
        q.push_back('{n, k, v});
        ->obs_ev;
    endtask

    // kind < 0 disables the check taken 4 clk after the 16th SCLK rise
    task automatic frame(input logic [23:0] d, input int n, input int kind,
                         input logic [7:0] exp16, input bit keep);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            mosi = d[23-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (i == 15 && kind >= 0) begin
                repeat (4) @(posedge clk);
                #1;
                expect_now("commit", kind, exp16);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (!keep) begin
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
        if (ena && n >= 16 && d[23] && !keep) nwr++;
    endtask

    task automatic read(input logic [1:0] a, input string n, input logic [7:0] v);
        frame({6'b0, a, 16'h0000}, 16, -1, 8'h00, 1'b0);
        expect_now(n, 2, v);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_now("rst_uio", 0, 8'h00);
        expect_now("rst_uo", 4, 8'h00);
        expect_now("rst_oe", 3, 8'hFF);
        rst_n = 1'b1;
        nwr = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_now("rst_uio", 0, 8'h00);
        expect_now("rst_uo", 4, 8'h00);
        expect_now("rst_oe", 3, 8'hFF);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame({8'h80, 8'h3C, 8'h00}, 16, 0, 8'h3C, 1'b0);
        read(2'd0, "rd_reg0", 8'h3C);
        frame({8'h81, 8'hFF, 8'h00}, 16, 1, 8'h7F, 1'b0);
        read(2'd1, "rd_reg1", 8'hFF);
        frame({8'h82, 8'h55, 8'h00}, 12, -1, 8'h00, 1'b0);
        read(2'd2, "rd_partial", 8'h00);
        frame({8'hFE, 8'hA6, 8'h00}, 16, -1, 8'h00, 1'b0);
        read(2'd2, "rd_reg2", 8'hA6);
        pulse_reset();
`ifdef SPI_TXN_COUNT_EN
        for (int i = 0; i < 3; i++) frame({8'h83, 8'h5A, 8'h00}, 16, -1, 8'h00, 1'b0);
        read(2'd3, "rd_cnt3", 8'h03);
        for (int i = 0; i < 253; i++) frame({8'h80, 8'h01, 8'h00}, 16, -1, 8'h00, 1'b0);
        read(2'd3, "rd_cnt_wrap", nwr[7:0]);
`else
        frame({8'h83, 8'h5A, 8'h00}, 16, -1, 8'h00, 1'b0);
        read(2'd3, "rd_reg3", 8'hA5);
`endif
        frame({8'h80, 8'h77, 8'h00}, 16, 0, 8'h77, 1'b0);
        frame({8'h80, 8'hAA, 8'h00}, 12, -1, 8'h00, 1'b1);
        pulse_reset();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        frame({8'h80, 8'h11, 8'h00}, 16, 0, 8'h11, 1'b0);
        ena = 1'b0;
        frame({8'h80, 8'h77, 8'h00}, 16, 0, 8'h11, 1'b0);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        frame({8'h80, 8'h12, 8'hFF}, 24, 0, 8'h12, 1'b0);
        expect_now("after24", 0, 8'h12);
        read(2'd0, "rd_after24", 8'h12);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d unchecked entries, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
